// File: rtl/serout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : serout_sequencer
//  Description : POKEY serial output sequencer. Frames each CPU-written byte
//                as start bit, eight data bits LSB first and stop bit, paced
//                by the selected audio timer underflow gated by the slow-clock
//                enable. Raises "serial output needed" and "transmission
//                finished" interrupt conditions.
//  Options     : SEROUT_TWO_TONE_EN - adds two-tone FSK output mode
//                (two_tone, tone1, tone2 inputs).
//  Revision    : 1.0 - initial release
// ============================================================================
module serout_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       enp,
   input  logic       bit_tick,
   input  logic       wr_serout,
   input  logic [7:0] din,
   input  logic       force_break,
`ifdef SEROUT_TWO_TONE_EN
   input  logic       two_tone,
   input  logic       tone1,
   input  logic       tone2,
`endif
   output logic       sod,
   output logic       irq_need,
   output logic       irq_done,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_hold;
   logic        r_hold_full;
   logic [7:0]  r_sr;
   logic [7:0]  w_sr_nxt;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nxt;
   logic        r_bit;
   logic        w_bit_nxt;
   logic        r_busy;
   logic        r_irq_need;
   logic        w_tick;
   logic        w_load;
   logic        w_framed;

   // A bit period only ends when the baud underflow coincides with the slow-clock enable
   assign w_tick = enp & bit_tick;

   // Next-state, shift/count update and the framed bit that the next state will present
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_bit_nxt   = 1'b1;
      if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (r_hold_full) begin
                  w_load      = 1'b1;
                  w_sr_nxt    = r_hold;
                  w_state_nxt = ST_START;
               end
            end
            ST_START: begin
               w_cnt_nxt   = 3'd0;
               w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
               w_sr_nxt  = {1'b0, r_sr[7:1]};
               w_cnt_nxt = r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  w_state_nxt = ST_STOP;
               end
            end
            ST_STOP: begin
               // Back-to-back frames skip the idle bit entirely
               if (r_hold_full) begin
                  w_load      = 1'b1;
                  w_sr_nxt    = r_hold;
                  w_state_nxt = ST_START;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
      case (w_state_nxt)
         ST_START: w_bit_nxt = 1'b0;
         ST_DATA:  w_bit_nxt = w_sr_nxt[0];
         default:  w_bit_nxt = 1'b1;
      endcase
   end

   // Sequencer registers: state, shift register, bit counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_sr       <= 8'h00;
         r_cnt      <= 3'd0;
         r_bit      <= 1'b1;
         r_busy     <= 1'b0;
         r_irq_need <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sr       <= w_sr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit      <= w_bit_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_irq_need <= w_load;
      end
   end

   // Holding register: a CPU write wins over a same-cycle load, which already took the old byte
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold      <= 8'h00;
         r_hold_full <= 1'b0;
      end else if (wr_serout) begin
         r_hold      <= din;
         r_hold_full <= 1'b1;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end

`ifdef SEROUT_TWO_TONE_EN
   // In two-tone mode the framed bit selects between the two timer square waves
   assign w_framed = two_tone ? (r_bit ? tone1 : tone2) : r_bit;
`else
   assign w_framed = r_bit;
`endif

   // Break overrides everything while the sequencer keeps running underneath
   assign sod      = force_break ? 1'b0 : w_framed;
   assign busy     = r_busy;
   assign irq_need = r_irq_need;
   assign irq_done = (r_state == ST_IDLE) & ~r_hold_full;

endmodule
`default_nettype wire

// File: doc/serout_sequencer.md
# serout_sequencer

Serial output sequencer for the POKEY core. It sits directly upstream of the SEROUT shift cell chain and frames each CPU-written byte as start bit, eight data bits LSB first, and stop bit. It drives the serial data output and raises the "serial output needed" and "transmission finished" interrupt conditions. Bit timing comes from the audio timer underflow selected by SKCTL, gated by the slow-clock enable pulse.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- enp  input  1  slow-clock enable pulse; sequencer state advances only when high.
- bit_tick  input  1  baud timer underflow; a bit period ends on a clk edge where enp=1 and bit_tick=1 (a "tick").
- wr_serout  input  1  CPU write strobe for SEROUT, one clk wide.
- din  input  8  CPU write data.
- force_break  input  1  SKCTL bit 7; forces sod low.
- sod  output  1  serial output data.
- irq_need  output  1  one-clk pulse: holding register consumed, next byte may be written.
- irq_done  output  1  level: no frame in progress and holding register empty.
- busy  output  1  level: state is not IDLE.

## Operation
- Holding register hold[7:0] with flag hold_full; shift register sr[7:0]; bit counter cnt[2:0].
- A write on wr_serout loads hold<=din and sets hold_full. This happens on any clk, regardless of enp.
- A write while hold_full=1 overwrites hold. No error is flagged.
- State machine IDLE, START, DATA, STOP. Transitions happen only on ticks:
  - IDLE: sod=1. On a tick with hold_full=1: sr<=hold, clear hold_full, pulse irq_need, go to START.
  - START: sod=0. On a tick: cnt<=0, go to DATA.
  - DATA: sod=sr[0]. On a tick: sr<=sr>>1, cnt<=cnt+1. When cnt==7, go to STOP instead; cnt wraps to 0.
  - STOP: sod=1. On a tick with hold_full=1: reload as in IDLE and go to START (back-to-back, no idle bit). Otherwise go to IDLE.
- A write and a load in the same cycle: the load uses the pre-write hold contents. hold then takes din and hold_full stays 1.
- force_break=1 drives sod=0 combinationally. The state machine keeps running underneath.
- irq_done = (state==IDLE) & ~hold_full.

## Timing
- Reset values: state=IDLE, sod=1, hold_full=0, hold=0, sr=0, cnt=0, irq_need=0, irq_done=1, busy=0.
- Reset during a frame aborts it immediately. sod=1 on the next edge and the holding byte is discarded.
- sod, busy and irq_need are registered. irq_done is registered via state and hold_full.
- A frame is exactly 10 bit periods: 1 start, 8 data, 1 stop.
- Latency from write to the start bit: the first tick after the write edge. A tick on the same edge as the write does not load it.
- irq_need is high for exactly one clk, on the edge after the loading tick.
- A tick with enp=0 is ignored. enp=1 without bit_tick holds the state.

## Configuration
- Macro SEROUT_TWO_TONE_EN.
- Defined: adds inputs two_tone (SKCTL bit 3), tone1 and tone2 (timer 1/2 square outputs). When two_tone=1, sod = (framed bit ? tone1 : tone2). force_break still has priority and forces sod=0.
- Undefined: those ports are absent and sod carries the framed bit directly.

## Test plan
- Reset: assert reset for 2 clk mid-frame -> sod=1, irq_done=1, busy=0, irq_need=0 on the next edge.
- Single byte: write 0xA5, then 10 ticks -> sod sequence 0,1,0,1,0,0,1,0,1,1. irq_need pulses once after the first tick. irq_done returns to 1 after the tenth tick.
- Back-to-back: write 0x00, then write 0xFF after irq_need -> 20 contiguous bit periods with no idle bit: 0,00000000,1,0,11111111,1.
- Overwrite: write 0x12 then 0x34 before any tick -> the frame transmits 0x34 only.
- Write on the load tick: hold_full=1 with 0x55, write 0x0F on the loading tick edge -> the first frame is 0x55, the second frame is 0x0F.
- Gating: bit_tick=1 with enp=0 for 50 clk -> no state change. force_break=1 mid-frame -> sod=0; release -> frame resumes with the correct bit for the current period.
